// File: rtl/mdl_serial_cntr.sv
// Bit-serial WIDTH-bit up/down counter held in a circular shift register, one bit per tick.
// Define MDL_SERIAL_CNTR_ZERO_DETECT_EN to add the o_ZERO all-zero flag.
//   state   | meaning
//   ST_IDLE | waiting for a start tick
//   ST_ROT  | shifting, WIDTH ticks
module mdl_serial_cntr #(
  parameter int WIDTH = 10
) (
  input  logic i_MCLK,
  input  logic i_RST,
  input  logic i_CEN_n,
  input  logic i_ROT_START_n,
  input  logic i_INC,
  input  logic i_DIR,
  input  logic i_CLR_n,
  input  logic i_LOAD,
  input  logic i_LOAD_BIT,
  output logic o_LSB,
  output logic o_CFLAG,
  output logic o_BUSY
`ifdef MDL_SERIAL_CNTR_ZERO_DETECT_EN
  ,
  output logic o_ZERO
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {ST_IDLE, ST_ROT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic             carry, clr_pend, rot_clr, rot_inc, rot_dir, loaded;
  logic             tick, last, inj, carry_nxt, new_bit;
`ifdef MDL_SERIAL_CNTR_ZERO_DETECT_EN
  logic             zero_acc;
`endif

  assign tick   = ~i_CEN_n;
  assign last   = (bit_cnt == CW'(WIDTH - 1));
  assign inj    = rot_inc & (bit_cnt == '0);
  assign o_LSB  = shreg[0];
  assign o_BUSY = (state == ST_ROT);

  // Carry and borrow share one flop; only the sense of bit0 differs.
  always_comb begin
    carry_nxt = 1'b0;
    new_bit   = 1'b0;
    if (rot_dir)
      carry_nxt = (~shreg[0] & carry) | (~shreg[0] & inj) | (carry & inj);
    else
      carry_nxt = (shreg[0] & carry) | (shreg[0] & inj) | (carry & inj);
    if (rot_clr)
      new_bit = 1'b0;
    else if (i_LOAD)
      new_bit = i_LOAD_BIT;
    else
      new_bit = shreg[0] ^ carry ^ inj;
  end

  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      carry    <= 1'b0;
      clr_pend <= 1'b0;
      rot_clr  <= 1'b0;
      rot_inc  <= 1'b0;
      rot_dir  <= 1'b0;
      loaded   <= 1'b0;
      o_CFLAG  <= 1'b0;
`ifdef MDL_SERIAL_CNTR_ZERO_DETECT_EN
      zero_acc <= 1'b1;
      o_ZERO   <= 1'b1;
`endif
    end else if (tick) begin
      if (!i_CLR_n)
        clr_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!i_ROT_START_n) begin
            state    <= ST_ROT;
            rot_inc  <= i_INC;
            rot_dir  <= i_DIR;
            rot_clr  <= clr_pend;
            carry    <= 1'b0;
            bit_cnt  <= '0;
            loaded   <= 1'b0;
`ifdef MDL_SERIAL_CNTR_ZERO_DETECT_EN
            zero_acc <= 1'b1;
`endif
          end
        end
        ST_ROT: begin
          shreg   <= {new_bit, shreg[WIDTH-1:1]};
          carry   <= carry_nxt;
          loaded  <= loaded | (i_LOAD & ~rot_clr);
          bit_cnt <= bit_cnt + CW'(1);
`ifdef MDL_SERIAL_CNTR_ZERO_DETECT_EN
          zero_acc <= zero_acc & ~new_bit;
`endif
          if (last) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            // A loaded or cleared rotation never reports a wrap.
            o_CFLAG <= carry_nxt & ~rot_clr & ~loaded & ~(i_LOAD & ~rot_clr);
            if (rot_clr && i_CLR_n)
              clr_pend <= 1'b0;
`ifdef MDL_SERIAL_CNTR_ZERO_DETECT_EN
            o_ZERO  <= zero_acc & ~new_bit;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdl_serial_cntr.sv
// Directed bench for mdl_serial_cntr (WIDTH=10): vector table of rotations plus hand-written corner sequences.
module tb_mdl_serial_cntr;

  localparam int W = 10;

  logic i_MCLK = 1'b0;
  logic i_RST, i_CEN_n, i_ROT_START_n, i_INC, i_DIR, i_CLR_n, i_LOAD, i_LOAD_BIT;
  logic o_LSB, o_CFLAG, o_BUSY;
`ifdef MDL_SERIAL_CNTR_ZERO_DETECT_EN
  logic o_ZERO;
`endif

  int tests = 0;
  int fails = 0;

  mdl_serial_cntr #(.WIDTH(W)) dut (
    .i_MCLK        (i_MCLK),
    .i_RST         (i_RST),
    .i_CEN_n       (i_CEN_n),
    .i_ROT_START_n (i_ROT_START_n),
    .i_INC         (i_INC),
    .i_DIR         (i_DIR),
    .i_CLR_n       (i_CLR_n),
    .i_LOAD        (i_LOAD),
    .i_LOAD_BIT    (i_LOAD_BIT),
    .o_LSB         (o_LSB),
    .o_CFLAG       (o_CFLAG),
    .o_BUSY        (o_BUSY)
`ifdef MDL_SERIAL_CNTR_ZERO_DETECT_EN
    ,
    .o_ZERO        (o_ZERO)
`endif
  );

  always #5 i_MCLK = ~i_MCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  typedef struct {
    logic       inc;
    logic       dir;
    logic       clr_before;
    logic [9:0] lmask;
    logic [9:0] lbits;
    logic [9:0] exp_val;
    logic       exp_cf;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_MCLK);
    #1;
  endtask

  // Start tick followed by W shift ticks; o_LSB before each shift gives the old value LSB first.
  task automatic rotate(input logic inc, input logic dir, input logic [9:0] lmask,
                        input logic [9:0] lbits, input int clr_at,
                        output logic [9:0] seen, output int busy_n, output logic busy_after);
    seen   = '0;
    busy_n = 0;
    i_CEN_n = 1'b0;
    i_INC = inc;
    i_DIR = dir;
    i_ROT_START_n = 1'b0;
    tick();
    i_ROT_START_n = 1'b1;
    for (int k = 0; k < W; k++) begin
      seen[k] = o_LSB;
      if (o_BUSY) busy_n++;
      i_LOAD     = lmask[k];
      i_LOAD_BIT = lbits[k];
      i_CLR_n    = (k == clr_at) ? 1'b0 : 1'b1;
      tick();
    end
    i_LOAD = 1'b0;
    i_LOAD_BIT = 1'b0;
    i_CLR_n = 1'b1;
    busy_after = o_BUSY;
  endtask

  task automatic readback(input string name, input logic [9:0] exp);
    logic [9:0] seen;
    int bn;
    logic ba;
    rotate(1'b0, 1'b0, 10'h000, 10'h000, -1, seen, bn, ba);
    chk(name, seen, exp);
  endtask

  initial begin
    logic [9:0] seen;
    int bn, shifts, cyc;
    logic ba, hold_busy;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 10'h000, 10'h000, 10'h001, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 10'h000, 10'h000, 10'h002, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 10'h000, 10'h000, 10'h003, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 10'h3FF, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 10'h000, 10'h000, 10'h000, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 10'h000, 10'h000, 10'h3FF, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 10'h000, 10'h000, 10'h3FE, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 10'h3FF, 10'h155, 10'h155, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 10'h3FF, 10'h3FF, 10'h000, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 10'h000, 10'h000, 10'h001, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 10'h00F, 10'h005, 10'h005, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 10'h3FF, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 10'h200, 10'h200, 10'h200, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 10'h000, 10'h000, 10'h1FF, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 10'h000, 10'h000, 10'h1FF, 1'b0};

    i_RST = 1'b1; i_CEN_n = 1'b0; i_ROT_START_n = 1'b1; i_INC = 1'b0; i_DIR = 1'b0;
    i_CLR_n = 1'b1; i_LOAD = 1'b0; i_LOAD_BIT = 1'b0;
    #1;
    chk("rst_busy", o_BUSY, 0);
    chk("rst_cflag", o_CFLAG, 0);
    chk("rst_lsb", o_LSB, 0);
`ifdef MDL_SERIAL_CNTR_ZERO_DETECT_EN
    chk("rst_zero", o_ZERO, 1);
`endif
    tick(); tick();
    i_RST = 1'b0;
    tick();

    for (int r = 0; r < 15; r++) begin
      if (vecs[r].clr_before) begin
        i_CLR_n = 1'b0;
        tick();
        i_CLR_n = 1'b1;
      end
      rotate(vecs[r].inc, vecs[r].dir, vecs[r].lmask, vecs[r].lbits, -1, seen, bn, ba);
      chk($sformatf("row%0d_busy_ticks", r), bn, W);
      chk($sformatf("row%0d_busy_end", r), ba, 0);
      chk($sformatf("row%0d_cflag", r), o_CFLAG, vecs[r].exp_cf);
`ifdef MDL_SERIAL_CNTR_ZERO_DETECT_EN
      chk($sformatf("row%0d_zero", r), o_ZERO, (vecs[r].exp_val == 10'h000));
`endif
      readback($sformatf("row%0d_value", r), vecs[r].exp_val);
    end

    // Repeated start mid-rotation plus a 5-cycle enable gap: still W shifts, +1 result.
    i_INC = 1'b1; i_DIR = 1'b0; i_CEN_n = 1'b0; i_ROT_START_n = 1'b0;
    tick();
    i_ROT_START_n = 1'b1;
    shifts = 0; cyc = 0; hold_busy = 1'b0;
    while (o_BUSY && cyc < 40) begin
      i_ROT_START_n = (cyc == 3) ? 1'b0 : 1'b1;
      i_CEN_n = (cyc >= 5 && cyc < 10) ? 1'b1 : 1'b0;
      if (!i_CEN_n) shifts++;
      tick();
      if (cyc == 9) hold_busy = o_BUSY;
      cyc++;
    end
    i_CEN_n = 1'b0; i_ROT_START_n = 1'b1;
    chk("gap_shift_count", shifts, W);
    chk("gap_busy_hold", hold_busy, 1);
    chk("gap_cflag", o_CFLAG, 0);
    readback("gap_value", 10'h200);

    // Clear requested during a rotation only applies to the next one.
    rotate(1'b1, 1'b0, 10'h000, 10'h000, 5, seen, bn, ba);
    chk("clrmid_busy_ticks", bn, W);
    readback("clrmid_value", 10'h201);
    chk("clrnext_cflag", o_CFLAG, 0);
    readback("clrnext_value", 10'h000);

    // Reset arriving mid-rotation aborts it immediately.
    rotate(1'b0, 1'b0, 10'h3FF, 10'h2AA, -1, seen, bn, ba);
    readback("pre_rst_value", 10'h2AA);
    i_INC = 1'b1; i_DIR = 1'b0; i_ROT_START_n = 1'b0;
    tick();
    i_ROT_START_n = 1'b1;
    tick(); tick(); tick();
    chk("pre_rst_busy", o_BUSY, 1);
    chk("pre_rst_lsb", o_LSB, 1);
    #2 i_RST = 1'b1;
    #1;
    chk("midrst_busy", o_BUSY, 0);
    chk("midrst_lsb", o_LSB, 0);
    chk("midrst_cflag", o_CFLAG, 0);
`ifdef MDL_SERIAL_CNTR_ZERO_DETECT_EN
    chk("midrst_zero", o_ZERO, 1);
`endif
    tick();
    i_RST = 1'b0;
    ba = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      ba = ba | o_BUSY;
    end
    chk("post_rst_idle", ba, 0);
    readback("post_rst_value", 10'h000);
    rotate(1'b1, 1'b0, 10'h000, 10'h000, -1, seen, bn, ba);
    readback("post_rst_inc", 10'h001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdl_serial_cntr.md
MDL_SERIAL_CNTR -- requirements
Module: mdl_serial_cntr

Interface
REQ-001 Parameter WIDTH, default 10, counter length in bits; legal range 2..32.
REQ-002 i_MCLK  input  1  master clock; all state changes on its rising edge.
REQ-003 i_RST  input  1  reset, asynchronous, active-high.
REQ-004 i_CEN_n  input  1  active-low clock enable; a "tick" is a rising i_MCLK edge with i_CEN_n=0.
REQ-005 i_ROT_START_n  input  1  active-low rotation start request, sampled on ticks.
REQ-006 i_INC  input  1  step enable for the rotation, latched at start.
REQ-007 i_DIR  input  1  step direction, 0=up (+1), 1=down (-1), latched at start.
REQ-008 i_CLR_n  input  1  active-low clear request; the next rotation loads zero.
REQ-009 i_LOAD  input  1  serial load enable; while high during a rotation, i_LOAD_BIT replaces the computed bit.
REQ-010 i_LOAD_BIT  input  1  serial preset data, LSB first.
REQ-011 o_LSB  output  1  current counter bit 0, the serial output tap.
REQ-012 o_CFLAG  output  1  wrap flag of the last completed rotation.
REQ-013 o_BUSY  output  1  rotation in progress.
REQ-014 o_ZERO  output  1  counter all-zero after last rotation (only with the macro, see Configuration).

Function
REQ-015 Storage: WIDTH-bit circular shift register; each shift moves bits toward bit 0 and writes the new value into bit WIDTH-1.
REQ-016 Idle: a tick with i_ROT_START_n=0 and o_BUSY=0 latches i_INC, i_DIR and the pending-clear flag, clears the internal carry/borrow, and sets o_BUSY.
REQ-017 Start with o_BUSY=1 is ignored; the rotation in progress is not restarted.
REQ-018 The rotation shifts on exactly WIDTH consecutive ticks after the start tick; o_BUSY falls on the last shift tick; no shift occurs while idle or on non-tick edges.
REQ-019 Bit arithmetic: new bit = bit0 XOR carry XOR (INC on the first shift only); up-carry = majority(bit0, carry, inj); down-borrow = majority(NOT bit0, carry, inj).
REQ-020 Net effect: INC=1 gives value+1 (up) or value-1 (down) modulo 2^WIDTH; INC=0 gives an unchanged value.
REQ-021 o_CFLAG updates on the last shift tick to the final carry/borrow: 1 for up with all-ones to zero, or for down with zero to all-ones; else 0. It holds until the next rotation completes.
REQ-022 Clear: an i_CLR_n=0 tick sets the pending-clear flag; a rotation started with the flag set writes 0 into every bit and gives o_CFLAG=0; the flag clears on that rotation's last tick.
REQ-023 An i_CLR_n=0 tick during a rotation affects only the following rotation.
REQ-024 Priority for the written bit: clear > i_LOAD > arithmetic; i_LOAD is evaluated per shift tick, so a partial load is legal.
REQ-025 A rotation with any loaded bit gives o_CFLAG=0.
REQ-026 o_LSB is combinational from register bit 0 and is valid every cycle.

Reset
REQ-027 i_RST=1 immediately forces: register=0, carry=0, pending-clear=0, o_BUSY=0, o_CFLAG=0, o_ZERO=1, bit counter=0.
REQ-028 Reset asserted mid-rotation aborts it; after release the block is idle and waits for a new start.

Configuration
REQ-029 Macro MDL_SERIAL_CNTR_ZERO_DETECT_EN: when defined, o_ZERO exists; it updates on the last shift tick to 1 if all WIDTH written bits were 0, else 0.
REQ-030 Without the macro, the o_ZERO port and its tracking logic are absent; all other behaviour is identical.

Verification (WIDTH=10)
REQ-031 Reset, then 3 rotations with INC=1, DIR=0 -> value 3, o_CFLAG=0, o_BUSY high for exactly 10 ticks per rotation.
REQ-032 Load 0x3FF by serial load, then one rotation up -> value 0x000, o_CFLAG=1, o_ZERO=1.
REQ-033 Value 0, one rotation down -> value 0x3FF, o_CFLAG=1; second rotation down -> 0x3FE, o_CFLAG=0.
REQ-034 Value 0x155, clear pulsed, then rotation with INC=1 and i_LOAD=1 -> value 0, o_CFLAG=0 (clear wins); next rotation up -> value 1.
REQ-035 Start pulsed again mid-rotation, and i_CEN_n held high for 5 cycles mid-rotation -> still exactly 10 shifts, correct +1 result.
REQ-036 i_RST pulsed at shift 4 of a rotation from 0x2AA -> register 0, o_BUSY=0 immediately; no further shifts until a new start.
